matrix_mult_core: RTL and testbench

- Input byte register plus a small registered matrix multiplier. Together they form the compute back end behind the matrix data loader.
- The loader feeds `data_in` through the byte register, assembles two packed operand matrices and their dimensions, then asserts `ready`.
- The block multiplies A (R1xC1) by B (R2xC2), up to 2x2, and holds the packed product on `res_mat`.

---
 rtl/matrix_mult_core_if.sv | 32 +++
 rtl/matrix_mult_core.sv | 97 +++++++++
 tb/tb_matrix_mult_core.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/matrix_mult_core_if.sv
// Operand/result bundle between the matrix data loader and matrix_mult_core.
// The master (loader) drives the operands; the slave (core) returns the registered results.
interface matrix_mult_core_if #(
  parameter int DATA_W  = 8,
  parameter int ELEM_W  = 16,
  parameter int MAX_DIM = 2
);
  localparam int BUS_W = MAX_DIM * MAX_DIM * ELEM_W;

  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_q;
  logic [BUS_W-1:0]  mat_a;
  logic [BUS_W-1:0]  mat_b;
  logic [3:0]        R1;
  logic [3:0]        C1;
  logic [3:0]        R2;
  logic [3:0]        C2;
  logic              ready;
  logic [BUS_W-1:0]  res_mat;
  logic              res_valid;
  logic              dim_err;

  modport master (
    output data_in, mat_a, mat_b, R1, C1, R2, C2, ready,
    input  data_q, res_mat, res_valid, dim_err
  );

  modport slave (
    input  data_in, mat_a, mat_b, R1, C1, R2, C2, ready,
    output data_q, res_mat, res_valid, dim_err
  );
endinterface

// File: rtl/matrix_mult_core.sv
// Input byte register plus a registered small-matrix multiplier (up to MAX_DIM x MAX_DIM).
// The product is formed combinationally from the live operands and captured whenever ready is high.
module matrix_mult_core #(
  parameter int DATA_W  = 8,
  parameter int ELEM_W  = 16,
  parameter int MAX_DIM = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  matrix_mult_core_if.slave  bus
);
  localparam int NSLOT  = MAX_DIM * MAX_DIM;
  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int BUS_W  = NSLOT * ELEM_W;

  logic [ELEM_W-1:0] a_elem   [NSLOT];
  logic [ELEM_W-1:0] b_elem   [NSLOT];
  logic [ELEM_W-1:0] res_slot [NSLOT];
  logic [BUS_W-1:0]  res_pack;
  logic [ELEM_W-1:0] acc;
  logic              legal;

  logic [DATA_W-1:0] byte_q, byte_d;
  logic [BUS_W-1:0]  res_q, res_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  // Slot 0 lives in the most significant element of the packed bus.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      assign a_elem[gi] = bus.mat_a[(NSLOT-1-gi)*ELEM_W +: ELEM_W];
      assign b_elem[gi] = bus.mat_b[(NSLOT-1-gi)*ELEM_W +: ELEM_W];
      assign res_pack[(NSLOT-1-gi)*ELEM_W +: ELEM_W] = res_slot[gi];
    end
  endgenerate

  always_comb begin
    legal = (bus.R1 != 4'd0) && (bus.R1 <= 4'(MAX_DIM)) &&
            (bus.C1 != 4'd0) && (bus.C1 <= 4'(MAX_DIM)) &&
            (bus.R2 != 4'd0) && (bus.R2 <= 4'(MAX_DIM)) &&
            (bus.C2 != 4'd0) && (bus.C2 <= 4'(MAX_DIM)) &&
            (bus.C1 == bus.R2);
    acc = '0;
    for (int s = 0; s < NSLOT; s++) begin
      res_slot[s] = '0;
    end
    // Element indices depend on the runtime column counts; unused slots stay zero.
    if (legal) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          if (i < int'(bus.R1) && j < int'(bus.C2)) begin
            acc = '0;
            for (int k = 0; k < MAX_DIM; k++) begin
              if (k < int'(bus.C1)) begin
                acc = acc + a_elem[SLOT_W'(i*int'(bus.C1) + k)] *
                            b_elem[SLOT_W'(k*int'(bus.C2) + j)];
              end
            end
            res_slot[SLOT_W'(i*int'(bus.C2) + j)] = acc;
          end
        end
      end
    end
  end

  always_comb begin
    byte_d  = bus.data_in;
    res_d   = res_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (bus.ready) begin
      res_d   = res_pack;
      valid_d = legal;
      err_d   = !legal;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byte_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      byte_q  <= byte_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.data_q    = byte_q;
  assign bus.res_mat   = res_q;
  assign bus.res_valid = valid_q;
  assign bus.dim_err   = err_q;
endmodule

// File: tb/tb_matrix_mult_core.sv
// Directed and random checks of matrix_mult_core against a plain-arithmetic matrix model.
module tb_matrix_mult_core;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [7:0]  exp_data;
  logic [63:0] exp_res;
  logic        exp_valid;
  logic        exp_err;

  matrix_mult_core_if #(.DATA_W(8), .ELEM_W(16), .MAX_DIM(2)) bus ();

  matrix_mult_core #(.DATA_W(8), .ELEM_W(16), .MAX_DIM(2)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit dims_ok(input int r1, input int c1, input int r2, input int c2);
    return (r1 >= 1 && r1 <= 2 && c1 >= 1 && c1 <= 2 &&
            r2 >= 1 && r2 <= 2 && c2 >= 1 && c2 <= 2 && c1 == r2);
  endfunction

  // Textbook product: unpack to element arrays, multiply, repack row-major with C2 columns.
  function automatic logic [63:0] model_mul(input logic [63:0] a, input logic [63:0] b,
                                            input int r1, input int c1, input int c2);
    longint ea [4];
    longint eb [4];
    longint sum;
    logic [63:0] res;
    for (int s = 0; s < 4; s++) begin
      ea[s] = longint'((a >> (16*(3-s))) & 64'hFFFF);
      eb[s] = longint'((b >> (16*(3-s))) & 64'hFFFF);
    end
    res = 64'h0;
    for (int i = 0; i < r1; i++) begin
      for (int j = 0; j < c2; j++) begin
        sum = 0;
        for (int k = 0; k < c1; k++) sum += ea[i*c1+k] * eb[k*c2+j];
        res |= (64'(sum) & 64'hFFFF) << (16*(3-(i*c2+j)));
      end
    end
    return res;
  endfunction

  task automatic cyc(input logic [7:0] d, input logic [63:0] a, input logic [63:0] b,
                     input int r1, input int c1, input int r2, input int c2, input logic rdy);
    bus.data_in = d;
    bus.mat_a   = a;
    bus.mat_b   = b;
    bus.R1      = 4'(r1);
    bus.C1      = 4'(c1);
    bus.R2      = 4'(r2);
    bus.C2      = 4'(c2);
    bus.ready   = rdy;
    exp_data = d;
    if (rdy) begin
      if (dims_ok(r1, c1, r2, c2)) begin
        exp_res   = model_mul(a, b, r1, c1, c2);
        exp_valid = 1'b1;
        exp_err   = 1'b0;
      end else begin
        exp_res   = 64'h0;
        exp_valid = 1'b0;
        exp_err   = 1'b1;
      end
    end
    @(negedge clk);
    check("data_q",    64'(bus.data_q),    64'(exp_data));
    check("res_mat",   bus.res_mat,        exp_res);
    check("res_valid", 64'(bus.res_valid), 64'(exp_valid));
    check("dim_err",   64'(bus.dim_err),   64'(exp_err));
    $display("cyc d=%h r1=%0d c1=%0d r2=%0d c2=%0d rdy=%0b res=%h v=%0b e=%0b",
             d, r1, c1, r2, c2, rdy, bus.res_mat, bus.res_valid, bus.dim_err);
  endtask

  initial begin
    logic [63:0] ra, rb;
    int r1, c1, r2, c2;
    total = 0;
    bad   = 0;

    // Reset held with busy inputs
    rst_n       = 1'b0;
    bus.data_in = 8'hFF;
    bus.mat_a   = 64'h0001_0002_0003_0004;
    bus.mat_b   = 64'h0005_0006_0007_0008;
    bus.R1 = 4'd2; bus.C1 = 4'd2; bus.R2 = 4'd2; bus.C2 = 4'd2;
    bus.ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_q",    64'(bus.data_q),    64'h0);
    check("rst_res_mat",   bus.res_mat,        64'h0);
    check("rst_res_valid", 64'(bus.res_valid), 64'h0);
    check("rst_dim_err",   64'(bus.dim_err),   64'h0);
    bus.ready = 1'b0;
    rst_n     = 1'b1;
    exp_data = 8'h0; exp_res = 64'h0; exp_valid = 1'b0; exp_err = 1'b0;

    // Byte path
    cyc(8'h3C, 64'h0, 64'h0, 0, 0, 0, 0, 1'b0);
    cyc(8'hA5, 64'h0, 64'h0, 0, 0, 0, 0, 1'b0);
    cyc(8'h07, 64'h0, 64'h0, 0, 0, 0, 0, 1'b0);

    // 2x2 with a one-cycle ready pulse, then hold with junk operands
    cyc(8'h11, 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008, 2, 2, 2, 2, 1'b1);
    check("spec_2x2", bus.res_mat, 64'h0013_0016_002B_0032);
    cyc(8'h12, 64'hDEAD_BEEF_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 2, 2, 1'b0);
    check("spec_2x2_hold", bus.res_mat, 64'h0013_0016_002B_0032);

    // Non-square shapes
    cyc(8'h13, 64'h0003_0004_AAAA_BBBB, 64'h0005_0006_CCCC_DDDD, 1, 2, 2, 1, 1'b1);
    check("spec_1x2x1", bus.res_mat, 64'h0027_0000_0000_0000);
    cyc(8'h14, 64'h0002_0003_EEEE_FFFF, 64'h0004_0005_1111_2222, 2, 1, 1, 2, 1'b1);
    check("spec_2x1x2", bus.res_mat, 64'h0008_000A_000C_000F);

    // Illegal dimensions, then recovery
    cyc(8'h15, 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008, 2, 2, 1, 2, 1'b1);
    cyc(8'h16, 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008, 0, 1, 1, 1, 1'b1);
    cyc(8'h17, 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008, 3, 2, 2, 2, 1'b1);
    cyc(8'h18, 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008, 2, 2, 2, 2, 1'b1);

    // Overflow truncation, then live update with ready held
    cyc(8'h19, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000, 1, 1, 1, 1, 1'b1);
    check("spec_overflow", bus.res_mat, 64'h0);
    cyc(8'h1A, 64'h0003_0000_0000_0000, 64'h0005_0000_0000_0000, 1, 1, 1, 1, 1'b1);
    check("spec_live", bus.res_mat, 64'h000F_0000_0000_0000);
    cyc(8'h1B, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 2, 2, 1'b1);

    // Asynchronous reset mid-cycle, then first result one edge after release
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_data_q",    64'(bus.data_q),    64'h0);
    check("async_res_mat",   bus.res_mat,        64'h0);
    check("async_res_valid", 64'(bus.res_valid), 64'h0);
    check("async_dim_err",   64'(bus.dim_err),   64'h0);
    @(negedge clk);
    bus.ready = 1'b0;
    rst_n     = 1'b1;
    exp_data = 8'h0; exp_res = 64'h0; exp_valid = 1'b0; exp_err = 1'b0;
    cyc(8'h1C, 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008, 2, 2, 2, 2, 1'b1);

    // Random traffic, mostly legal shapes
    for (int n = 0; n < 60; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) begin
        r1 = int'($urandom_range(1, 2));
        c1 = int'($urandom_range(1, 2));
        r2 = c1;
        c2 = int'($urandom_range(1, 2));
      end else begin
        r1 = int'($urandom_range(0, 3));
        c1 = int'($urandom_range(0, 3));
        r2 = int'($urandom_range(0, 3));
        c2 = int'($urandom_range(0, 3));
      end
      cyc(8'($urandom), ra, rb, r1, c1, r2, c2, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
